// File: rtl/tdm_demux_receiver.sv
// -----------------------------------------------------------------------------
// tdm_demux_receiver
//
// Receive end of the time-division serial link. A 1-bit stream, framed by a
// sync pulse on bit 0, carries CHANNELS words of WIDTH bits each (channel 0
// first, MSB first within a word). The block de-interleaves one frame into a
// shift register and updates every channel output at once when the frame's
// last bit is sampled.
//
// Optional feature macro: TDM_PARITY_EN
//   defined   -> every word is followed by one even-parity bit; a frame with
//                any parity mismatch ends with frame_err instead of
//                frame_valid and leaves ch_data untouched.
//   undefined -> no parity bits; frame_err only reports a mid-frame sync.
//
// Ports
//   clk          rising-edge clock, one serial bit per cycle
//   reset_n      synchronous active-low reset
//   sync         high in the cycle carrying bit 0 of a frame
//   din          serial data bit
//   ch_data      channel k at [k*WIDTH +: WIDTH]; last good frame
//   frame_valid  one-cycle pulse when ch_data is updated
//   frame_err    one-cycle pulse when a frame is aborted or fails parity
//   busy         high while a frame is being received
// -----------------------------------------------------------------------------
module tdm_demux_receiver #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync,
  input  logic                      din,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      busy
);

`ifdef TDM_PARITY_EN
  localparam int WORD_BITS = WIDTH + 1;
  localparam bit PARITY    = 1'b1;
`else
  localparam int WORD_BITS = WIDTH;
  localparam bit PARITY    = 1'b0;
`endif

  localparam int DATA_BITS = CHANNELS * WIDTH;
  localparam int BIT_W     = $clog2(WORD_BITS + 1);
  localparam int CH_W      = $clog2(CHANNELS);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_PAR  = BIT_W'(WIDTH);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  typedef enum logic {HUNT, RECV} state_e;

  state_e                 state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;   // index of the next bit within its word
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;     // channel of the next bit
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;       // data bits only, first bit ends up at MSB
  logic                   par_acc_q, par_acc_d;   // XOR of the current word's data bits
  logic                   bad_q, bad_d;           // parity failure seen earlier in this frame
  logic [DATA_BITS-1:0]   ch_data_q, ch_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;

  // Working copies of the position and accumulators for the bit sampled
  // this cycle; a restart (fresh sync) overrides them before the bit is
  // processed so a new frame and a continuing frame share one datapath.
  logic                   take;
  logic                   is_par;
  logic [BIT_W-1:0]       cur_bit;
  logic [CH_W-1:0]        cur_ch;
  logic                   acc;
  logic                   bad;
  logic [DATA_BITS-1:0]   sr;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    ch_cnt_d      = ch_cnt_q;
    shreg_d       = shreg_q;
    par_acc_d     = par_acc_q;
    bad_d         = bad_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // NOTE: these are chained intermediates inside one combinational block,
    // so they use blocking assignments and are read after being updated.
    take    = 1'b0;
    is_par  = 1'b0;
    cur_bit = bit_cnt_q;
    cur_ch  = ch_cnt_q;
    acc     = par_acc_q;
    bad     = bad_q;
    sr      = shreg_q;

    if (state_q == HUNT) begin
      if (sync) begin
        take    = 1'b1;
        cur_bit = '0;
        cur_ch  = '0;
        acc     = 1'b0;
        bad     = 1'b0;
        sr      = '0;
      end
    end else begin
      take = 1'b1;
      // A sync on the last bit is ignored: that bit completes the frame.
      if (sync && !(bit_cnt_q == BIT_LAST && ch_cnt_q == CH_LAST)) begin
        frame_err_d = 1'b1;
        cur_bit     = '0;
        cur_ch      = '0;
        acc         = 1'b0;
        bad         = 1'b0;
        sr          = '0;
      end
    end

    if (take) begin
      is_par = PARITY && (cur_bit == BIT_PAR);
      if (is_par) begin
        // Even parity: the parity bit equals the XOR of the word's data bits.
        if (din != acc) bad = 1'b1;
        acc = 1'b0;
      end else begin
        sr  = {sr[DATA_BITS-2:0], din};
        acc = acc ^ din;
      end

      if (cur_bit == BIT_LAST && cur_ch == CH_LAST) begin
        state_d   = HUNT;
        bit_cnt_d = '0;
        ch_cnt_d  = '0;
        if (bad) begin
          frame_err_d = 1'b1;
        end else begin
          frame_valid_d = 1'b1;
          // Channel 0 arrived first, so it sits in the top word of sr.
          for (int k = 0; k < CHANNELS; k++) begin
            ch_data_d[k*WIDTH +: WIDTH] = sr[(CHANNELS-1-k)*WIDTH +: WIDTH];
          end
        end
      end else begin
        state_d = RECV;
        if (cur_bit == BIT_LAST) begin
          bit_cnt_d = '0;
          ch_cnt_d  = cur_ch + 1'b1;
        end else begin
          bit_cnt_d = cur_bit + 1'b1;
          ch_cnt_d  = cur_ch;
        end
      end

      shreg_d   = sr;
      par_acc_d = acc;
      bad_d     = bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the shift register is cleared too even though every frame
      // start reloads it, so no stale frame content survives a reset.
      state_q       <= HUNT;
      bit_cnt_q     <= '0;
      ch_cnt_q      <= '0;
      shreg_q       <= '0;
      par_acc_q     <= 1'b0;
      bad_q         <= 1'b0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_cnt_q      <= ch_cnt_d;
      shreg_q       <= shreg_d;
      par_acc_q     <= par_acc_d;
      bad_q         <= bad_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == RECV);

endmodule
